// File: rtl/spi_arb.sv
// spi_arb
// Two-requester arbiter and sequencer in front of a single SPI_mnrch master.
// Requester 0 (inertial interface) and requester 1 (e.g. A2D interface) share
// one master. Grants alternate round-robin when both ask, the grant is held
// for a whole transaction, an idle gap is enforced between transactions, and
// a transaction that never completes is closed with a timeout error.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0_i / req1_i     transaction request level from each requester
//   cmd0_i / cmd1_i     command word, held stable while the request is high
//   gnt0_o / gnt1_o     requester currently owns the master
//   done0_o / done1_o   one-cycle pulse when the owner's transaction ends
//   resp0_o / resp1_o   response of the last transaction of that requester
//   err_o               one-cycle pulse alongside doneN when it timed out
//   m_snd_o, m_cmd_o    start pulse and command towards SPI_mnrch
//   m_done_i, m_resp_i  completion pulse and response from SPI_mnrch
module spi_arb #(
    parameter int CMD_W   = 16,
    parameter int RESP_W  = 16,
    parameter int GAP_CYC = 4,
    parameter int TO_CYC  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic [CMD_W-1:0]  cmd0_i,
    output logic              gnt0_o,
    output logic              done0_o,
    output logic [RESP_W-1:0] resp0_o,
    input  logic              req1_i,
    input  logic [CMD_W-1:0]  cmd1_i,
    output logic              gnt1_o,
    output logic              done1_o,
    output logic [RESP_W-1:0] resp1_o,
    output logic              err_o,
    output logic              m_snd_o,
    output logic [CMD_W-1:0]  m_cmd_o,
    input  logic              m_done_i,
    input  logic [RESP_W-1:0] m_resp_i
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        BUSY,
        GAP
    } state_t;

    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(TO_CYC - 1);

    state_t              state_q, state_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                err_q, err_d;
    logic [RESP_W-1:0]   resp0_q, resp0_d;
    logic [RESP_W-1:0]   resp1_q, resp1_d;
    logic [CMD_W-1:0]    mCmd_q, mCmd_d;
    logic                lastGnt_q, lastGnt_d;
    logic [7:0]          gapCnt_q, gapCnt_d;
    logic [15:0]         toCnt_q, toCnt_d;
    logic [15:0]         toCntInc;
    logic                pick1;
    logic                finish;
    logic                timedOut;
    logic [RESP_W-1:0]   respSel;

    // State register. lastGnt resets to 1 so that a tie straight after reset
    // goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            resp0_q   <= '0;
            resp1_q   <= '0;
            mCmd_q    <= '0;
            lastGnt_q <= 1'b1;
            gapCnt_q  <= '0;
            toCnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            resp0_q   <= resp0_d;
            resp1_q   <= resp1_d;
            mCmd_q    <= mCmd_d;
            lastGnt_q <= lastGnt_d;
            gapCnt_q  <= gapCnt_d;
            toCnt_q   <= toCnt_d;
        end
    end

    // Next-state logic. Everything holds by default and the done/err pulses
    // default low, so each state only spells out what it changes.
    always_comb begin
        state_d   = state_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
        resp0_d   = resp0_q;
        resp1_d   = resp1_q;
        mCmd_d    = mCmd_q;
        lastGnt_d = lastGnt_q;
        gapCnt_d  = gapCnt_q;
        toCnt_d   = toCnt_q;
        toCntInc  = (toCnt_q == 16'hFFFF) ? toCnt_q : toCnt_q + 16'd1;
        pick1     = req1_i && (!req0_i || !lastGnt_q);
        finish    = 1'b0;
        timedOut  = 1'b0;
        respSel   = m_resp_i;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    if (pick1) begin
                        gnt1_d = 1'b1;
                        mCmd_d = cmd1_i;
                    end else begin
                        gnt0_d = 1'b1;
                        mCmd_d = cmd0_i;
                    end
                    state_d = SEND;
                end
            end

            SEND: begin
                toCnt_d = '0;
                state_d = BUSY;
            end

            BUSY: begin
                // A completion wins over a timeout that would fire on the
                // same edge.
                if (m_done_i) begin
                    finish = 1'b1;
                end else if (toCntInc == TO_LAST) begin
                    finish   = 1'b1;
                    timedOut = 1'b1;
                    respSel  = '1;
                end else begin
                    toCnt_d = toCntInc;
                end

                if (finish) begin
                    if (gnt1_q) begin
                        resp1_d   = respSel;
                        done1_d   = 1'b1;
                        lastGnt_d = 1'b1;
                    end else begin
                        resp0_d   = respSel;
                        done0_d   = 1'b1;
                        lastGnt_d = 1'b0;
                    end
                    gnt0_d   = 1'b0;
                    gnt1_d   = 1'b0;
                    err_d    = timedOut;
                    gapCnt_d = '0;
                    state_d  = GAP;
                end
            end

            GAP: begin
                // Requests are ignored here so SS_n has risen and the master
                // is idle before the next start pulse.
                if (gapCnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0_o  = gnt0_q;
    assign gnt1_o  = gnt1_q;
    assign done0_o = done0_q;
    assign done1_o = done1_q;
    assign err_o   = err_q;
    assign resp0_o = resp0_q;
    assign resp1_o = resp1_q;
    assign m_cmd_o = mCmd_q;
    assign m_snd_o = (state_q == SEND);

endmodule

// File: tb/tb_spi_arb.sv
module tb_spi_arb;

    logic        clk;
    logic        rst_n;
    logic        req0;
    logic [15:0] cmd0;
    logic        gnt0;
    logic        done0;
    logic [15:0] resp0;
    logic        req1;
    logic [15:0] cmd1;
    logic        gnt1;
    logic        done1;
    logic [15:0] resp1;
    logic        err;
    logic        mSnd;
    logic [15:0] mCmd;
    logic        mDone;
    logic [15:0] mResp;

    int vectors;
    int miscompares;
    int done0Count;
    int done1Count;
    bit overlapSeen;
    bit doubleDoneSeen;

    spi_arb #(
        .CMD_W  (16),
        .RESP_W (16),
        .GAP_CYC(4),
        .TO_CYC (64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0_i  (req0),
        .cmd0_i  (cmd0),
        .gnt0_o  (gnt0),
        .done0_o (done0),
        .resp0_o (resp0),
        .req1_i  (req1),
        .cmd1_i  (cmd1),
        .gnt1_o  (gnt1),
        .done1_o (done1),
        .resp1_o (resp1),
        .err_o   (err),
        .m_snd_o (mSnd),
        .m_cmd_o (mCmd),
        .m_done_i(mDone),
        .m_resp_i(mResp)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-run watch for overlapping grants, double done pulses, and a tally
    // of done pulses per requester.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 && gnt1) overlapSeen = 1'b1;
            if (done0 && done1) doubleDoneSeen = 1'b1;
            if (done0) done0Count++;
            if (done1) done1Count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic [15:0] c0,
                                 input logic r1, input logic [15:0] c1);
        req0 = r0;
        cmd0 = c0;
        req1 = r1;
        cmd1 = c1;
    endtask

    task automatic driveMaster(input logic md, input logic [15:0] mr);
        mDone = md;
        mResp = mr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Steps until m_snd is seen, within a bounded number of cycles.
    task automatic waitSnd(input string tag, output int cycles);
        cycles = 0;
        while (mSnd !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
        checkOutput({tag, "_snd_seen"}, {31'd0, mSnd}, 32'd1);
    endtask

    // Directed sequence: reset, single request, tie, fairness, timeout,
    // robustness corner cases, and reset in the middle of a transaction.
    initial begin
        int cycles;
        bit expOne;

        vectors        = 0;
        miscompares    = 0;
        done0Count     = 0;
        done1Count     = 0;
        overlapSeen    = 1'b0;
        doubleDoneSeen = 1'b0;
        rst_n          = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        driveMaster(1'b0, 16'h0000);

        repeat (2) step();
        checkOutput("rst_gnt0",  {31'd0, gnt0},  32'd0);
        checkOutput("rst_gnt1",  {31'd0, gnt1},  32'd0);
        checkOutput("rst_msnd",  {31'd0, mSnd},  32'd0);
        checkOutput("rst_mcmd",  {16'd0, mCmd},  32'd0);
        checkOutput("rst_resp0", {16'd0, resp0}, 32'd0);
        checkOutput("rst_resp1", {16'd0, resp1}, 32'd0);
        checkOutput("rst_err",   {31'd0, err},   32'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 0, master answers 40 cycles later.
        applyStimulus(1'b1, 16'hA655, 1'b0, 16'h0000);
        step();
        checkOutput("t1_gnt0", {31'd0, gnt0}, 32'd1);
        checkOutput("t1_gnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("t1_msnd", {31'd0, mSnd}, 32'd1);
        checkOutput("t1_mcmd", {16'd0, mCmd}, 32'h0000A655);
        step();
        checkOutput("t1_msnd_one", {31'd0, mSnd}, 32'd0);
        repeat (39) step();
        checkOutput("t1_no_early_done", {31'd0, done0}, 32'd0);
        driveMaster(1'b1, 16'h00F3);
        step();
        driveMaster(1'b0, 16'h0000);
        applyStimulus(1'b0, 16'hA655, 1'b0, 16'h0000);
        checkOutput("t1_done0", {31'd0, done0}, 32'd1);
        checkOutput("t1_resp0", {16'd0, resp0}, 32'h000000F3);
        checkOutput("t1_gnt0_drop", {31'd0, gnt0}, 32'd0);
        checkOutput("t1_done1", {31'd0, done1}, 32'd0);
        checkOutput("t1_resp1", {16'd0, resp1}, 32'd0);
        checkOutput("t1_err", {31'd0, err}, 32'd0);
        step();
        checkOutput("t1_done0_pulse", {31'd0, done0}, 32'd0);
        repeat (6) step();

        // Both requesting straight out of reset: requester 0 first, then
        // requester 1 exactly four idle cycles after done0.
        rst_n = 1'b0;
        applyStimulus(1'b1, 16'h0D02, 1'b1, 16'h1234);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("t2_gnt0", {31'd0, gnt0}, 32'd1);
        checkOutput("t2_gnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("t2_mcmd0", {16'd0, mCmd}, 32'h00000D02);
        step();
        driveMaster(1'b1, 16'h1111);
        step();
        driveMaster(1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0D02, 1'b1, 16'h1234);
        checkOutput("t2_done0", {31'd0, done0}, 32'd1);
        checkOutput("t2_resp0", {16'd0, resp0}, 32'h00001111);
        repeat (4) step();
        checkOutput("t2_gap_msnd", {31'd0, mSnd}, 32'd0);
        checkOutput("t2_gap_gnt1", {31'd0, gnt1}, 32'd0);
        step();
        checkOutput("t2_msnd1", {31'd0, mSnd}, 32'd1);
        checkOutput("t2_gnt1_on", {31'd0, gnt1}, 32'd1);
        checkOutput("t2_mcmd1", {16'd0, mCmd}, 32'h00001234);
        step();
        driveMaster(1'b1, 16'h2222);
        step();
        driveMaster(1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0D02, 1'b0, 16'h1234);
        checkOutput("t2_done1", {31'd0, done1}, 32'd1);
        checkOutput("t2_resp1", {16'd0, resp1}, 32'h00002222);
        checkOutput("t2_resp0_kept", {16'd0, resp0}, 32'h00001111);
        repeat (6) step();

        // Fairness: both held high for six transactions; last grant was 1.
        applyStimulus(1'b1, 16'h0A0A, 1'b1, 16'h0B0B);
        expOne = 1'b0;
        for (int i = 0; i < 6; i++) begin
            waitSnd($sformatf("fair%0d", i), cycles);
            if (i > 0) begin
                checkOutput($sformatf("fair%0d_gap_ok", i),
                            {31'd0, (cycles + 1 - 1) >= 4}, 32'd1);
            end
            checkOutput($sformatf("fair%0d_gnt1", i), {31'd0, gnt1}, {31'd0, expOne});
            checkOutput($sformatf("fair%0d_mcmd", i), {16'd0, mCmd},
                        expOne ? 32'h00000B0B : 32'h00000A0A);
            step();
            driveMaster(1'b1, 16'(i));
            step();
            driveMaster(1'b0, 16'h0000);
            if (i == 5) applyStimulus(1'b0, 16'h0A0A, 1'b0, 16'h0B0B);
            checkOutput($sformatf("fair%0d_done", i),
                        {30'd0, done1, done0}, expOne ? 32'd2 : 32'd1);
            expOne = ~expOne;
        end
        repeat (6) step();

        // Timeout: no m_done ever; close 63 cycles after entering BUSY.
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h5A5A);
        step();
        checkOutput("to_msnd", {31'd0, mSnd}, 32'd1);
        step();
        repeat (62) step();
        checkOutput("to_not_yet_done1", {31'd0, done1}, 32'd0);
        checkOutput("to_not_yet_err", {31'd0, err}, 32'd0);
        step();
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h5A5A);
        checkOutput("to_done1", {31'd0, done1}, 32'd1);
        checkOutput("to_err", {31'd0, err}, 32'd1);
        checkOutput("to_resp1", {16'd0, resp1}, 32'h0000FFFF);
        checkOutput("to_gnt1_drop", {31'd0, gnt1}, 32'd0);
        step();
        checkOutput("to_err_pulse", {31'd0, err}, 32'd0);
        repeat (6) step();

        // Command changes after grant and req0 drops mid-BUSY.
        applyStimulus(1'b1, 16'hC3C3, 1'b0, 16'h0000);
        step();
        checkOutput("rb_mcmd", {16'd0, mCmd}, 32'h0000C3C3);
        applyStimulus(1'b1, 16'hBEEF, 1'b0, 16'h0000);
        step();
        applyStimulus(1'b0, 16'hBEEF, 1'b0, 16'h0000);
        repeat (3) step();
        checkOutput("rb_mcmd_latched", {16'd0, mCmd}, 32'h0000C3C3);
        checkOutput("rb_gnt0_held", {31'd0, gnt0}, 32'd1);
        driveMaster(1'b1, 16'h0A0A);
        step();
        driveMaster(1'b0, 16'h0000);
        checkOutput("rb_done0", {31'd0, done0}, 32'd1);
        checkOutput("rb_resp0", {16'd0, resp0}, 32'h00000A0A);
        repeat (6) step();

        // Spurious m_done while IDLE.
        driveMaster(1'b1, 16'h7777);
        step();
        checkOutput("sp_done0", {31'd0, done0}, 32'd0);
        step();
        driveMaster(1'b0, 16'h0000);
        checkOutput("sp_done1", {31'd0, done1}, 32'd0);
        checkOutput("sp_resp0", {16'd0, resp0}, 32'h00000A0A);
        checkOutput("sp_resp1", {16'd0, resp1}, 32'h0000FFFF);
        step();

        // Reset while BUSY, then a fresh request from requester 1.
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'hABCD);
        step();
        step();
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'hABCD);
        step();
        checkOutput("mr_gnt1_busy", {31'd0, gnt1}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_gnt1", {31'd0, gnt1}, 32'd0);
        checkOutput("mr_msnd", {31'd0, mSnd}, 32'd0);
        checkOutput("mr_mcmd", {16'd0, mCmd}, 32'd0);
        checkOutput("mr_resp0", {16'd0, resp0}, 32'd0);
        checkOutput("mr_resp1", {16'd0, resp1}, 32'd0);
        checkOutput("mr_err_done", {29'd0, err, done1, done0}, 32'd0);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 16'h1357);
        step();
        checkOutput("mr_new_gnt1", {31'd0, gnt1}, 32'd1);
        checkOutput("mr_new_msnd", {31'd0, mSnd}, 32'd1);
        checkOutput("mr_new_mcmd", {16'd0, mCmd}, 32'h00001357);
        step();
        driveMaster(1'b1, 16'h2468);
        step();
        driveMaster(1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h1357);
        checkOutput("mr_new_done1", {31'd0, done1}, 32'd1);
        checkOutput("mr_new_resp1", {16'd0, resp1}, 32'h00002468);
        repeat (6) step();

        // Whole-run invariants.
        checkOutput("never_overlap", {31'd0, overlapSeen}, 32'd0);
        checkOutput("never_double_done", {31'd0, doubleDoneSeen}, 32'd0);
        checkOutput("done0_total", 32'(done0Count), 32'd6);
        checkOutput("done1_total", 32'(done1Count), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
